// File: rtl/fpadd_operand_sequencer.sv
// ============================================================================
// Module   : fpadd_operand_sequencer
// Purpose  : Operand-pair FIFO and sequencer in front of the serial FP adder;
//            captures each live result into a valid/ready output slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpadd_operand_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        add_ready,
    input  logic [31:0] add_sum,
    output logic [31:0] add_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        idle
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        DRIVE_A   = 2'd1,
        DRIVE_B   = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [31:0]          r_mem_a [DEPTH];
    logic [31:0]          r_mem_b [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_rdy_q;
    logic                 r_live;
    logic                 r_out_valid;
    logic [31:0]          r_out_sum;
    logic [31:0]          r_op_a;
    logic [31:0]          r_op_b;

    logic                 w_push;
    logic                 w_rise;
    logic                 w_rise_act;
    logic                 w_slot_free;
    logic                 w_issue;
    logic                 w_capture;

    assign in_ready    = (r_count < c_cnt_w'(DEPTH));
    assign w_push      = in_valid & in_ready;
    assign w_rise      = add_ready & ~r_rdy_q;
    assign w_rise_act  = w_rise & ((r_state == WAIT_RISE) | (r_state == WAIT_DONE));
    // Issue only into a guaranteed-empty output slot so no result is overwritten.
    assign w_slot_free = (~r_out_valid | out_ready) & ~r_live;
    assign w_issue     = w_rise_act & (r_count != '0) & w_slot_free;
    assign w_capture   = w_rise_act & r_live;

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign idle      = (r_count == '0) & ~r_live & ~r_out_valid;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            unique case ({w_push, w_issue})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state     <= WAIT_RISE;
            r_rdy_q     <= 1'b0;
            r_live      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
        end else begin
            r_state <= w_state_next;
            r_rdy_q <= add_ready;
            if (w_rise_act) begin
                r_live <= w_issue;
                r_op_a <= w_issue ? r_mem_a[r_rd_ptr] : 32'd0;
                r_op_b <= w_issue ? r_mem_b[r_rd_ptr] : 32'd0;
            end
            // A capture in the same cycle as a downstream handshake wins.
            if (w_capture) begin
                r_out_sum   <= add_sum;
                r_out_valid <= 1'b1;
            end else if (r_out_valid & out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        add_op       = 32'd0;
        case (r_state)
            WAIT_RISE, WAIT_DONE: begin
                if (w_rise) begin
                    w_state_next = DRIVE_A;
                end
            end
            DRIVE_A: begin
                add_op       = r_op_a;
                w_state_next = DRIVE_B;
            end
            DRIVE_B: begin
                add_op       = r_op_b;
                w_state_next = WAIT_DONE;
            end
            default: w_state_next = WAIT_RISE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_fpadd_operand_sequencer.sv
// ============================================================================
// Module   : tb_fpadd_operand_sequencer
// Purpose  : Self-checking bench with a free-running serial adder model and
//            an in-order pair/result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpadd_operand_sequencer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        add_ready;
    logic [31:0] add_sum;
    logic [31:0] add_op;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic        idle;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [63:0] iss_q[$];

    always #5 clock = ~clock;

    fpadd_operand_sequencer #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .nreset    (nreset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_ready (add_ready),
        .add_sum   (add_sum),
        .add_op    (add_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .idle      (idle)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact for the positive integer-valued operands the bench generates.
    function automatic logic [31:0] int_to_float(input int n);
        int          msb;
        logic [31:0] m;
        msb = 0;
        if (n == 0) return 32'd0;
        for (int i = 0; i < 31; i++) begin
            if ((n >> i) != 0) msb = i;
        end
        m = 32'(n) << (23 - msb);
        return {1'b0, 8'(127 + msb), m[22:0]};
    endfunction

    function automatic int float_to_int(input logic [31:0] x);
        int e;
        e = int'(x[30:23]) - 127;
        return int'({9'd0, 1'b1, x[22:0]} >> (23 - e));
    endfunction

    // Reference sum: adder's special cases first, then plain integer addition.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
            return 32'hFFFFFFFF;
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        if (a[30:0] == 0) return b;
        if (b[30:0] == 0) return a;
        return int_to_float(float_to_int(a) + float_to_int(b));
    endfunction

    // Serial adder model: phase 0/1 ready high, A sampled at end of 1, B at end of 2.
    int          ph;
    int          per;
    logic [31:0] opa;
    logic [31:0] opb;

    always @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            add_ready <= 1'b0;
            add_sum   <= '0;
            ph        <= -4;
            per       <= 7;
            opa       <= '0;
            opb       <= '0;
        end else begin
            if (ph == 1) opa <= add_op;
            if (ph == 2) begin
                opb <= add_op;
                per <= (opa == 0 && add_op == 0) ? 7 : 7 + int'($urandom_range(0, 5));
            end
            if (ph >= 0 && ph == per - 1) begin
                ph        <= 0;
                add_ready <= 1'b1;
                add_sum   <= fp_add(opa, opb);
            end else begin
                ph        <= ph + 1;
                add_ready <= (ph + 1 == 0) || (ph + 1 == 1);
            end
        end
    end

    always @(negedge clock) begin
        if (nreset) begin
            if (ph != 1 && ph != 2) check("add_op_quiet", add_op, 32'd0);
            if (ph == 2 && !(opa == 0 && add_op == 0)) begin
                check("issue_pending", 32'(iss_q.size() > 0), 32'd1);
                if (iss_q.size() > 0) begin
                    check("issue_a", opa, iss_q[0][63:32]);
                    check("issue_b", add_op, iss_q[0][31:0]);
                    void'(iss_q.pop_front());
                end
            end
        end
    end

    logic        prev_hold;
    logic [31:0] prev_sum;

    always @(negedge clock) begin
        if (!nreset) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_sum", out_sum, prev_sum);
            end
            if (out_valid && out_ready) begin
                check("result_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("result", out_sum, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            prev_hold <= out_valid && !out_ready;
            prev_sum  <= out_sum;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic record(input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back(fp_add(a, b));
        iss_q.push_back({a, b});
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 1000) begin
            tick();
            n++;
        end
        check("push_timeout", 32'(n < 1000), 32'd1);
        tick();
        in_valid = 1'b0;
        if (n < 1000) record(a, b);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(idle && exp_q.size() == 0) && n < 3000) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(n < 3000), 32'd1);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", out_sum, 32'd0);
        check("rst_add_op", add_op, 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
    endtask

    function automatic logic [31:0] rnd_a();
        return int_to_float(int'($urandom_range(1, 1000)));
    endfunction

    function automatic logic [31:0] rnd_b();
        return int_to_float(int'($urandom_range(0, 1000)));
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          accepted;
        int          n;
        bit          acc;
        bit          done;

        repeat (3) tick();
        check_reset_values();
        nreset = 1'b1;

        // Empty FIFO: only dummy transactions
        out_ready = 1'b1;
        repeat (50) tick();
        check("empty_out_valid", 32'(out_valid), 32'd0);
        check("empty_idle", 32'(idle), 32'd1);

        push(32'h3F800000, 32'h40000000);
        wait_idle();

        push(32'h3F800000, 32'h3F800000);
        push(32'h00000000, 32'h40490FDB);
        push(32'h7F800000, 32'h3F800000);
        push(32'h7FC00000, 32'h3F800000);
        wait_idle();

        // Blocked output slot: exactly one pair issues, DEPTH more fill the FIFO
        out_ready = 1'b0;
        accepted  = 0;
        a = rnd_a();
        b = rnd_b();
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int i = 0; i < 80; i++) begin
            acc = in_ready;
            tick();
            if (acc && in_valid) begin
                record(a, b);
                accepted++;
                if (accepted < DEPTH + 2) begin
                    a = rnd_a();
                    b = rnd_b();
                    in_a = a;
                    in_b = b;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("hold_accepted", 32'(accepted), 32'(DEPTH + 1));
        check("hold_in_ready", 32'(in_ready), 32'd0);
        check("hold_out_valid", 32'(out_valid), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (accepted == DEPTH + 1) push(a, b);
        wait_idle();

        // Random pairs with random downstream backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3 * DEPTH * 3; i++) begin
                    push(rnd_a(), rnd_b());
                    repeat ($urandom_range(0, 2)) tick();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        wait_idle();

        // Reset while a result is held and the adder is mid-transaction
        out_ready = 1'b0;
        push(32'h3F800000, 32'h3F800000);
        push(32'h40000000, 32'h40000000);
        n = 0;
        while (!(out_valid && ph >= 3) && n < 500) begin
            tick();
            n++;
        end
        check("pre_reset_wait", 32'(n < 500), 32'd1);
        nreset = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        iss_q.delete();
        repeat (2) tick();
        check_reset_values();
        nreset    = 1'b1;
        out_ready = 1'b1;
        push(32'h40400000, 32'h3F800000);
        wait_idle();

        check("final_exp_empty", 32'(exp_q.size()), 32'd0);
        check("final_iss_empty", 32'(iss_q.size()), 32'd0);
        check("final_idle", 32'(idle), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
